// File: rtl/hp2vga_pkg.sv
// Shared types and constants for the HP2VGA capture path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package hp2vga_pkg;

    typedef enum logic [2:0] {
        WAIT_VS,
        V_SKIP,
        H_SKIP,
        CAPTURE,
        LINE_WAIT
    } RX_STATE_T;

    localparam logic [7:0] GREY_OFF  = 8'h00;
    localparam logic [7:0] GREY_HALF = 8'h80;
    localparam logic [7:0] GREY_FULL = 8'hFF;

    localparam int BRAM_AW = 14;

    // Two source bits collapse to three grey levels; intensity only matters when the pixel is lit.
    function automatic logic [7:0] grey_map(input logic video, input logic intensity);
        if (!video) begin
            return GREY_OFF;
        end
        return intensity ? GREY_FULL : GREY_HALF;
    endfunction

endpackage

// File: rtl/hp_video_rx_if.sv
// Frame BRAM write port plus the frame timing pulses handed to the VGA output side.
// Latency: none, wiring only.
// Backpressure: none; the BRAM port accepts a write every cycle.
interface hp_video_rx_if;
    import hp2vga_pkg::*;

    logic [BRAM_AW-1:0] BRAM_ADDR;
    logic [7:0]         BRAM_DIN;
    logic               BRAM_WE;
    logic               VGA_SYNC;
    logic               FRAME_DONE;

    modport master (
        output BRAM_ADDR,
        output BRAM_DIN,
        output BRAM_WE,
        output VGA_SYNC,
        output FRAME_DONE
    );

    modport slave (
        input BRAM_ADDR,
        input BRAM_DIN,
        input BRAM_WE,
        input VGA_SYNC,
        input FRAME_DONE
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with a falling-edge detect off a third flop.
// Latency: o_sync lags the pin by 2 CLK; o_fall is high for 1 cycle, acted on 3 CLK after the pin.
// Backpressure: none.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser chain plus the history flop used for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_fall = r_s3 & ~r_s2;
endmodule

// File: rtl/hp_video_rx.sv
// Captures the HP raster into the frame BRAM as one 8-bit grey level per source pixel.
// Latency: sync edges act 3 CLK after the pin; a write appears 1 CLK after its sample clock.
// Backpressure: none; ENABLE low drops back to waiting for VS and suppresses writes.
module hp_video_rx
    import hp2vga_pkg::*;
#(
    parameter int SAMPLE_DIV   = 4,
    parameter int SAMPLE_PHASE = 2,
    parameter int H_OFFSET     = 20,
    parameter int V_OFFSET     = 8,
    parameter int H_ACTIVE     = 144,
    parameter int V_ACTIVE     = 112
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          ENABLE,
    input  logic          HP_HS,
    input  logic          HP_VS,
    input  logic          HP_VIDEO,
    input  logic          HP_INTENSITY,
    hp_video_rx_if.master bram
);
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0]      LP_PH_LAST    = PW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0]      LP_PH_SAMPLE  = PW'(SAMPLE_PHASE);
    localparam logic [7:0]         LP_H_OFF_LAST = 8'((H_OFFSET > 0) ? H_OFFSET - 1 : 0);
    localparam logic [7:0]         LP_V_OFF_LAST = 8'((V_OFFSET > 0) ? V_OFFSET - 1 : 0);
    localparam logic [7:0]         LP_PIX_LAST   = 8'(H_ACTIVE - 1);
    localparam logic [7:0]         LP_LINE_LAST  = 8'(V_ACTIVE - 1);
    localparam logic [BRAM_AW-1:0] LP_LINE_STEP  = BRAM_AW'(H_ACTIVE);
    // With no horizontal offset a line goes straight from the HS edge into capture.
    localparam RX_STATE_T          LP_LINE_ENTRY = (H_OFFSET > 0) ? H_SKIP : CAPTURE;

    logic w_hs_s, w_hs_fall, w_vs_s, w_vs_fall;
    logic w_vid_s, w_vid_fall, w_int_s, w_int_fall;
    logic w_unused;

    sync_edge u_sync_hs  (.i_clk(CLK), .i_rst_n(RESET_N), .i_async(HP_HS),        .o_sync(w_hs_s),  .o_fall(w_hs_fall));
    sync_edge u_sync_vs  (.i_clk(CLK), .i_rst_n(RESET_N), .i_async(HP_VS),        .o_sync(w_vs_s),  .o_fall(w_vs_fall));
    sync_edge u_sync_vid (.i_clk(CLK), .i_rst_n(RESET_N), .i_async(HP_VIDEO),     .o_sync(w_vid_s), .o_fall(w_vid_fall));
    sync_edge u_sync_int (.i_clk(CLK), .i_rst_n(RESET_N), .i_async(HP_INTENSITY), .o_sync(w_int_s), .o_fall(w_int_fall));

    // Sync levels and data edges are not needed; only HS/VS edges and data levels drive the FSM.
    assign w_unused = w_hs_s ^ w_vs_s ^ w_vid_fall ^ w_int_fall;

    RX_STATE_T          r_state, w_state_nxt;
    logic [PW-1:0]      r_phase, w_phase_nxt, w_phase_inc;
    logic [7:0]         r_hcnt,  w_hcnt_nxt;
    logic [7:0]         r_vcnt,  w_vcnt_nxt;
    logic [7:0]         r_pix,   w_pix_nxt;
    logic [7:0]         r_line,  w_line_nxt;
    logic [BRAM_AW-1:0] r_base,  w_base_nxt;
    logic [BRAM_AW-1:0] r_addr,  w_addr_nxt;
    logic [7:0]         r_din,   w_din_nxt;
    logic               r_we,    w_we_nxt;
    logic               r_sync,  w_sync_nxt;
    logic               r_done,  w_done_nxt;
    logic               w_wrap, w_line_start;

    assign w_wrap      = (r_phase == LP_PH_LAST);
    assign w_phase_inc = w_wrap ? '0 : r_phase + 1'b1;

    // Next state and next datapath values; ENABLE, then VS, then HS take priority in that order.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_hcnt_nxt   = r_hcnt;
        w_vcnt_nxt   = r_vcnt;
        w_pix_nxt    = r_pix;
        w_line_nxt   = r_line;
        w_base_nxt   = r_base;
        w_addr_nxt   = r_addr;
        w_din_nxt    = r_din;
        w_we_nxt     = 1'b0;
        w_sync_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_line_start = 1'b0;

        if (!ENABLE) begin
            w_state_nxt = WAIT_VS;
        end else if (w_vs_fall) begin
            // Frame start, or abort of a frame in progress: both restart from address 0.
            w_state_nxt = V_SKIP;
            w_sync_nxt  = 1'b1;
            w_vcnt_nxt  = '0;
            w_line_nxt  = '0;
            w_base_nxt  = '0;
            w_addr_nxt  = '0;
        end else begin
            case (r_state)
                WAIT_VS: begin
                end
                V_SKIP: begin
                    if (w_hs_fall) begin
                        if (r_vcnt >= LP_V_OFF_LAST) begin
                            w_line_start = 1'b1;
                        end else begin
                            w_vcnt_nxt = r_vcnt + 8'd1;
                        end
                    end
                end
                H_SKIP, CAPTURE: begin
                    if (w_hs_fall) begin
                        // Short line: skip the remaining pixels but keep the next line on its own row.
                        w_base_nxt = r_base + LP_LINE_STEP;
                        w_line_nxt = r_line + 8'd1;
                        if (r_line == LP_LINE_LAST) begin
                            w_state_nxt = WAIT_VS;
                        end else begin
                            w_line_start = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = w_phase_inc;
                        if (r_state == H_SKIP) begin
                            if (w_wrap) begin
                                if (r_hcnt == LP_H_OFF_LAST) begin
                                    w_state_nxt = CAPTURE;
                                end else begin
                                    w_hcnt_nxt = r_hcnt + 8'd1;
                                end
                            end
                        end else if (r_phase == LP_PH_SAMPLE) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = r_base + BRAM_AW'(r_pix);
                            w_din_nxt  = grey_map(w_vid_s, w_int_s);
                            if (r_pix == LP_PIX_LAST) begin
                                w_base_nxt = r_base + LP_LINE_STEP;
                                w_line_nxt = r_line + 8'd1;
                                if (r_line == LP_LINE_LAST) begin
                                    w_done_nxt  = 1'b1;
                                    w_state_nxt = WAIT_VS;
                                end else begin
                                    w_state_nxt = LINE_WAIT;
                                end
                            end else begin
                                w_pix_nxt = r_pix + 8'd1;
                            end
                        end
                    end
                end
                LINE_WAIT: begin
                    if (w_hs_fall) begin
                        w_line_start = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_VS;
                end
            endcase

            // Every new line restarts pixel timing from the HS edge that opened it.
            if (w_line_start) begin
                w_state_nxt = LP_LINE_ENTRY;
                w_phase_nxt = '0;
                w_hcnt_nxt  = '0;
                w_pix_nxt   = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= WAIT_VS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters and registered BRAM/timing outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_phase <= '0;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_pix   <= '0;
            r_line  <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
            r_pix   <= w_pix_nxt;
            r_line  <= w_line_nxt;
            r_base  <= w_base_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_we    <= w_we_nxt;
            r_sync  <= w_sync_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bram.BRAM_ADDR  = r_addr;
    assign bram.BRAM_DIN   = r_din;
    assign bram.BRAM_WE    = r_we;
    assign bram.VGA_SYNC   = r_sync;
    assign bram.FRAME_DONE = r_done;
endmodule

// File: tb/tb_hp_video_rx.sv
// Directed bench for hp_video_rx with a reduced frame height to keep run time short.
// Latency checks: VGA_SYNC 3 CLK after the VS pin, pixel k written 86+4k CLK after its line's HS pin.
// Backpressure: none; writes are logged one entry per BRAM_WE cycle.
module tb_hp_video_rx;
    localparam int DIV    = 4;
    localparam int PH     = 2;
    localparam int HOFF   = 20;
    localparam int VOFF   = 3;
    localparam int HACT   = 144;
    localparam int VACT   = 6;
    localparam int LINE   = 700;
    // Clock index (from a line's HS pin edge) at which source pixel 0 is driven.
    localparam int PIX_C0 = 2 + HOFF * DIV;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic ENABLE = 1'b0;
    logic HP_HS = 1'b1;
    logic HP_VS = 1'b1;
    logic HP_VIDEO = 1'b0;
    logic HP_INTENSITY = 1'b0;

    logic [13:0] wr_addr[$];
    logic [7:0]  wr_dat[$];
    bit          wr_done[$];
    int n_done = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always #5 CLK = ~CLK;

    hp_video_rx_if bus();

    hp_video_rx #(
        .SAMPLE_DIV(DIV), .SAMPLE_PHASE(PH), .H_OFFSET(HOFF),
        .V_OFFSET(VOFF), .H_ACTIVE(HACT), .V_ACTIVE(VACT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
        .HP_HS(HP_HS), .HP_VS(HP_VS), .HP_VIDEO(HP_VIDEO), .HP_INTENSITY(HP_INTENSITY),
        .bram(bus)
    );

    // Write logger, sampled just after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (bus.BRAM_WE) begin
            wr_addr.push_back(bus.BRAM_ADDR);
            wr_dat.push_back(bus.BRAM_DIN);
            wr_done.push_back(bus.FRAME_DONE);
        end
        if (bus.FRAME_DONE) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] addr_at(input int i);
        if (i >= 0 && i < wr_addr.size()) return wr_addr[i];
        return 14'h3FFF;
    endfunction

    // One source line starting with its HS pin edge; alt gives on/off pixels, else all on.
    task automatic src_line(input bit alt, input bit inten, input int len, input int en_off, input int en_on);
        for (int c = 0; c < len; c++) begin
            int k;
            k = (c - PIX_C0) / DIV;
            HP_HS = (c < 8) ? 1'b0 : 1'b1;
            if (c == en_off) ENABLE = 1'b0;
            if (c == en_on)  ENABLE = 1'b1;
            if (c >= PIX_C0 && c < PIX_C0 + DIV * HACT) begin
                HP_VIDEO     = alt ? ((k % 2) == 0) : 1'b1;
                HP_INTENSITY = inten;
            end else begin
                HP_VIDEO     = 1'b0;
                HP_INTENSITY = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    // VS pin pulse; checks VGA_SYNC is a single pulse 3 CLK after the pin edge.
    task automatic vs_frame(input string tag);
        HP_HS = 1'b1;
        HP_VIDEO = 1'b0;
        HP_VS = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 2) chk({tag, "_sync_before"}, bus.VGA_SYNC, 1'b0);
            if (c == 3) chk({tag, "_sync_pulse"},  bus.VGA_SYNC, 1'b1);
            if (c == 4) chk({tag, "_sync_after"},  bus.VGA_SYNC, 1'b0);
            if (c == 20) HP_VS = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic skip_lines();
        for (int s = 0; s < VOFF - 1; s++) src_line(1'b0, 1'b0, LINE, -1, -1);
    endtask

    initial begin
        int q0, n, bad, bad2, dn;
        logic [7:0] e8;

        // Reset state
        repeat (4) @(negedge CLK);
        chk("rst_we",   bus.BRAM_WE, 1'b0);
        chk("rst_sync", bus.VGA_SYNC, 1'b0);
        chk("rst_done", bus.FRAME_DONE, 1'b0);
        chk("rst_addr", bus.BRAM_ADDR, 14'd0);
        chk("rst_din",  bus.BRAM_DIN, 8'd0);
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        repeat (10) @(negedge CLK);

        // Full frame, all pixels half bright
        vs_frame("t1");
        q0 = wr_addr.size();
        skip_lines();
        chk("t1_skip_no_wr", wr_addr.size(), q0);
        for (int l = 0; l < VACT; l++) src_line(1'b0, 1'b0, LINE, -1, -1);
        n = wr_addr.size() - q0;
        chk("t1_wr_count", n, HACT * VACT);
        bad = 0; bad2 = 0; dn = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_dat[q0 + i] !== 8'h80) bad++;
            if (wr_addr[q0 + i] !== 14'(i)) bad2++;
            if (wr_done[q0 + i]) dn++;
        end
        chk("t1_data_80", bad, 0);
        chk("t1_addr_seq", bad2, 0);
        chk("t1_last_addr", addr_at(q0 + n - 1), HACT * VACT - 1);
        chk("t1_done_flags", dn, 1);
        chk("t1_done_on_last", (n > 0) ? wr_done[q0 + n - 1] : 1'b0, 1'b1);
        chk("t1_done_total", n_done, 1);

        // Alternating pixels, full intensity on line 0 only
        vs_frame("t3");
        skip_lines();
        q0 = wr_addr.size();
        src_line(1'b1, 1'b1, LINE, -1, -1);
        src_line(1'b1, 1'b0, LINE, -1, -1);
        n = wr_addr.size() - q0;
        chk("t3_wr_count", n, 2 * HACT);
        bad = 0; bad2 = 0;
        for (int i = 0; i < n && i < 2 * HACT; i++) begin
            e8 = ((i % HACT) % 2 == 0) ? ((i < HACT) ? 8'hFF : 8'h80) : 8'h00;
            if (wr_dat[q0 + i] !== e8) begin
                if (i < HACT) bad++; else bad2++;
            end
        end
        chk("t3_line0_data", bad, 0);
        chk("t3_line1_data", bad2, 0);
        chk("t3_line1_first_addr", addr_at(q0 + HACT), HACT);

        // Line 3 cut short by HS after 100 pixels
        vs_frame("t4");
        skip_lines();
        q0 = wr_addr.size();
        for (int l = 0; l < 3; l++) src_line(1'b0, 1'b0, LINE, -1, -1);
        src_line(1'b0, 1'b0, 482, -1, -1);
        src_line(1'b0, 1'b0, LINE, -1, -1);
        chk("t4_wr_count", wr_addr.size() - q0, 4 * HACT + 100);
        chk("t4_trunc_last", addr_at(q0 + 3 * HACT + 99), 3 * HACT + 99);
        chk("t4_line4_first", addr_at(q0 + 3 * HACT + 100), 4 * HACT);

        // VS during line 4 aborts the frame
        vs_frame("t5a");
        skip_lines();
        for (int l = 0; l < 4; l++) src_line(1'b0, 1'b0, LINE, -1, -1);
        src_line(1'b0, 1'b0, 300, -1, -1);
        vs_frame("t5b");
        chk("t5_no_done", n_done, 1);
        q0 = wr_addr.size();
        skip_lines();
        chk("t5_skip_no_wr", wr_addr.size(), q0);
        src_line(1'b0, 1'b0, LINE, -1, -1);
        chk("t5_restart_addr", addr_at(q0), 14'd0);
        chk("t5_restart_count", wr_addr.size() - q0, HACT);

        // ENABLE dropped just before pixel 54's write, raised again later in the line
        vs_frame("t6a");
        skip_lines();
        q0 = wr_addr.size();
        src_line(1'b0, 1'b0, LINE, 301, 340);
        chk("t6_wr_count", wr_addr.size() - q0, 54);
        chk("t6_last_addr", addr_at(q0 + 53), 14'd53);
        src_line(1'b0, 1'b0, LINE, -1, -1);
        chk("t6_no_wr_reenable", wr_addr.size() - q0, 54);
        chk("t6_addr_hold", bus.BRAM_ADDR, 14'd53);
        chk("t6_din_hold", bus.BRAM_DIN, 8'h80);
        vs_frame("t6b");
        skip_lines();
        q0 = wr_addr.size();
        src_line(1'b0, 1'b0, LINE, -1, -1);
        chk("t6_resume_addr", addr_at(q0), 14'd0);
        chk("t6_resume_count", wr_addr.size() - q0, HACT);
        chk("final_done_total", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hp_video_rx.md
Name: hp_video_rx

Overview:
Capture side of the HP2VGA path. Samples the HP instrument's raw raster (HSYNC, VSYNC, video, intensity) on the system clock and writes one 8-bit grey level per source pixel into the shared frame BRAM, using linear addressing from 0. Emits a one-cycle frame-start pulse so the VGA output side can lock its raster to the source.

Parameters:
SAMPLE_DIV, 4, system clocks per source pixel (≥2)
SAMPLE_PHASE, 2, clock within a pixel period at which video is sampled (< SAMPLE_DIV)
H_OFFSET, 20, source pixel periods from the HS falling edge to the first captured pixel
V_OFFSET, 8, HS falling edges from the VS falling edge to the first captured line
H_ACTIVE, 144, pixels captured per line
V_ACTIVE, 112, lines captured per frame (H_ACTIVE*V_ACTIVE ≤ 16384)

Ports:
CLK  in  1  system clock, also the BRAM write clock
RESET_N  in  1  synchronous, active-low reset
ENABLE  in  1  capture enable
HP_HS  in  1  source horizontal sync, asynchronous, active-low
HP_VS  in  1  source vertical sync, asynchronous, active-low
HP_VIDEO  in  1  source pixel on, asynchronous
HP_INTENSITY  in  1  source full-bright flag, asynchronous
BRAM_ADDR  out  14  write address
BRAM_DIN  out  8  write data
BRAM_WE  out  1  write strobe, one cycle per pixel
VGA_SYNC  out  1  one-cycle frame-start pulse
FRAME_DONE  out  1  one-cycle pulse after the last pixel of a complete frame is written

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: RESET_N low at a CLK edge resets the block.
- Reset values: all outputs are 0; state is WAIT_VS; all counters are 0.
- Input synchronisation: each HP_* input passes through 2 flops. Edge detection uses a third flop. The falling edge of synced HS or VS is visible 3 CLK after the pin transition.
- Grey-level map, from the synced inputs:
  - VIDEO=0 → 0x00
  - VIDEO=1, INTENSITY=0 → 0x80
  - VIDEO=1, INTENSITY=1 → 0xFF
- States:
  - WAIT_VS: on a VS falling edge with ENABLE=1, pulse VGA_SYNC for 1 cycle, clear the line count, line base and address, then go to V_SKIP.
  - V_SKIP: count HS falling edges. When the count reaches V_OFFSET, go to H_SKIP. With V_OFFSET=0, the next HS edge starts H_SKIP directly.
  - H_SKIP: entered on an HS falling edge. The phase counter resets to 0 on that edge. Count H_OFFSET full pixel periods, then go to CAPTURE.
  - CAPTURE: phase counter runs 0..SAMPLE_DIV-1 and wraps. When phase==SAMPLE_PHASE, assert BRAM_WE for 1 cycle with BRAM_DIN = mapped value and BRAM_ADDR = line base + pixel index. The registered outputs appear 1 cycle after the sample edge. After the H_ACTIVE-th write:
    - line base += H_ACTIVE and line count increments;
    - if line count == V_ACTIVE, pulse FRAME_DONE with the final write and go to WAIT_VS;
    - otherwise go to LINE_WAIT.
  - LINE_WAIT: on an HS falling edge, go to H_SKIP.
- Boundary conditions:
  - HS edge inside CAPTURE before H_ACTIVE pixels: the line is truncated. Line base still advances by H_ACTIVE, so the next line stays aligned. Then H_SKIP starts for the next line. The truncated pixels are not written and keep their old BRAM contents.
  - VS falling edge in any state other than WAIT_VS: the frame is aborted. Restart exactly as in WAIT_VS, including the VGA_SYNC pulse and address 0. No FRAME_DONE.
  - HS and VS edges in the same cycle: VS wins.
  - ENABLE low: go to WAIT_VS at the next edge. BRAM_WE is forced to 0 that cycle. Outputs otherwise hold.
  - RESET_N low mid-write: BRAM_WE is 0 on the next cycle.
- Width rules: BRAM_ADDR is 14-bit unsigned and never exceeds H_ACTIVE*V_ACTIVE-1. The pixel index is 8 bits and the line count is 8 bits.

Decomposition:
- Package hp2vga_pkg holds:
  - state enum RX_STATE_T: WAIT_VS, V_SKIP, H_SKIP, CAPTURE, LINE_WAIT;
  - constants GREY_OFF=8'h00, GREY_HALF=8'h80, GREY_FULL=8'hFF;
  - BRAM_AW=14.
- One sub-module, sync_edge: 2-flop synchroniser plus falling-edge detector, 1-bit. Instantiated for HS and VS. Video and intensity use its synchroniser output only.

Test Plan:
- Reset, then a VS falling edge → VGA_SYNC pulses exactly 1 cycle, 3 CLK after the pin edge; BRAM_WE stays 0 through the 8 skipped lines.
- Full frame with default parameters, constant VIDEO=1, INTENSITY=0 → 16128 writes, all data 0x80, addresses 0..16127 strictly increasing; FRAME_DONE coincides with the write to address 16127.
- Source pattern alternating pixels on/off, INTENSITY=1 on even lines → line 0 data is FF,00,FF,…; line 1 data is 80,00,80,…; the first write of line 1 is to address 144.
- HS edge after 100 pixels of line 3 → writes stop at address 3*144+99=531; line 4 begins at address 576.
- VS edge during line 50 → VGA_SYNC pulses, no FRAME_DONE, the next write after 8 lines is to address 0.
- ENABLE deasserted mid-line → BRAM_WE is 0 from the next cycle. ENABLE reasserted → no writes until the next VS edge.
